iob_2p_mem_rd_stream: RTL



---
 rtl/iob_2p_mem_rd_stream_pkg.sv | 15 +
 rtl/iob_skid_fifo2.sv | 68 ++++++
 rtl/iob_2p_mem_rd_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/iob_2p_mem_rd_stream_pkg.sv
// Shared definitions for the read-stream controller: FSM encoding and skid depth.
package iob_2p_mem_rd_stream_pkg;

   // FSM state encoding shared by the controller and anything that observes it.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Entries in the output skid buffer, and width of its occupancy count.
   localparam int SKID_DEPTH = 2;
   localparam int SKID_CNT_W = 2;

endpackage

// File: rtl/iob_skid_fifo2.sv
// Two-entry valid/ready buffer with occupancy count. The head entry drives
// out_data directly from a flop. A push and a pop in the same cycle are allowed
// at any occupancy. The writer must not push into a full buffer unless it is
// also popping in that cycle.
module iob_skid_fifo2
   import iob_2p_mem_rd_stream_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [DATA_W-1:0]     out_data,
   output logic [SKID_CNT_W-1:0] count
);

   logic [DATA_W-1:0]     head_q, head_d;
   logic [DATA_W-1:0]     tail_q, tail_d;
   logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
   logic                  pop;

   // Next entry contents and occupancy for push, pop, or both.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      pop    = (cnt_q != '0) && out_ready;
      cnt_d  = cnt_q + SKID_CNT_W'(in_valid) - SKID_CNT_W'(pop);
      case ({in_valid, pop})
         2'b10: begin
            if (cnt_q == '0) head_d = in_data;
            else             tail_d = in_data;
         end
         2'b01: begin
            if (cnt_q == SKID_CNT_W'(2)) head_d = tail_q;
         end
         2'b11: begin
            if (cnt_q == SKID_CNT_W'(1)) begin
               head_d = in_data;
            end else begin
               head_d = tail_q;
               tail_d = in_data;
            end
         end
         default: ;
      endcase
   end

   // Buffer storage and count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   assign out_valid = (cnt_q != '0);
   assign out_data  = head_q;
   assign count     = cnt_q;

endmodule

// File: rtl/iob_2p_mem_rd_stream.sv
// Read-side streaming controller for the wide port of the two-port memory.
// A start command issues a burst of sequential reads. The one-cycle read
// latency is absorbed, and the returned words are presented on a valid/ready
// stream through a two-entry skid buffer.
// Build option: define IOB_MEM_RD_STREAM_WRAP_EN to let bursts wrap past the top
// address. Without it, a start that would run past the end of memory is
// rejected with an err pulse.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; len==0 gives done only, overrun gives err
// ST_RUN   | issuing reads while words remain and buffer credit allows
// ST_DRAIN | all reads issued; wait for buffer and in-flight read to empty
module iob_2p_mem_rd_stream
   import iob_2p_mem_rd_stream_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 7,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              r_en,
   output logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [LEN_W-1:0]      rem_q, rem_d;
   logic                  inflight_q, inflight_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [SKID_CNT_W-1:0] fifo_cnt;
   logic                  pop;
   logic [2:0]            occ_next;
   logic                  issue;
   logic                  fits;

   // Credit includes this cycle's pop so the stream sustains one word per cycle.
   always_comb begin
      pop      = out_valid && out_ready;
      occ_next = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
      issue    = (state_q == ST_RUN) && (rem_q != '0) && (occ_next < 3'(SKID_DEPTH));
   end

`ifdef IOB_MEM_RD_STREAM_WRAP_EN
   assign fits = 1'b1;
`else
   logic [LEN_W:0] end_addr;
   localparam logic [LEN_W:0] MEM_WORDS = (LEN_W+1)'(1) << ADDR_W;
   assign end_addr = (LEN_W+1)'(base_addr) + (LEN_W+1)'(len);
   assign fits     = (end_addr <= MEM_WORDS);
`endif

   // Next-state and output logic for the burst FSM.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      inflight_d = issue;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len == '0) begin
                  done_d = 1'b1;
               end else if (!fits) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_RUN;
                  addr_d  = base_addr;
                  rem_d   = len;
               end
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d = addr_q + 1'b1;
               rem_d  = rem_q - 1'b1;
               if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Finish on the cycle the last word leaves, so done follows it directly.
            if (occ_next == '0 && !inflight_d) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // FSM registers and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         rem_q      <= '0;
         inflight_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         inflight_q <= inflight_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
   assign r_en   = issue;
   assign r_addr = addr_q;

   iob_skid_fifo2 #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inflight_q),
      .in_data   (r_data),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (fifo_cnt)
   );

endmodule
